// File: rtl/register_bank_if.sv
// Bus bundle for register_bank: write port, two read ports and PC control/status.
interface register_bank_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4
);
    logic                 WE;
    logic [ADDR_SIZE-1:0] WA;
    logic [DATA_SIZE-1:0] WD;
    logic [ADDR_SIZE-1:0] RA1;
    logic [ADDR_SIZE-1:0] RA2;
    logic                 PC_EN;
    logic [DATA_SIZE-1:0] RD1;
    logic [DATA_SIZE-1:0] RD2;
    logic [DATA_SIZE-1:0] PC;
    logic                 PC_WRAP;

    modport master (
        output WE, WA, WD, RA1, RA2, PC_EN,
        input  RD1, RD2, PC, PC_WRAP
    );

    modport slave (
        input  WE, WA, WD, RA1, RA2, PC_EN,
        output RD1, RD2, PC, PC_WRAP
    );
endinterface

// File: rtl/register_bank.sv
// Register bank with one write port, two registered read ports and a PC in the top register.
// Optional macro REGISTER_BANK_BYPASS_EN forwards same-edge write data to the read ports.
module register_bank #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 16,
    parameter int ADDR_SIZE = 4,
    parameter int PC_STEP   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    register_bank_if.slave   bus
);
    localparam logic [ADDR_SIZE-1:0] LAST   = ADDR_SIZE'(DEPTH - 1);
    localparam logic [DATA_SIZE-1:0] STEP   = DATA_SIZE'(PC_STEP);
    localparam logic [DATA_SIZE-1:0] OFFSET = DATA_SIZE'(2 * PC_STEP);

    logic [DATA_SIZE-1:0] regs [DEPTH];
    logic [DATA_SIZE-1:0] rd_q   [2];
    logic [DATA_SIZE-1:0] rd_nxt [2];
    logic [ADDR_SIZE-1:0] ra     [2];
    logic                 wrap_q;
    logic [DATA_SIZE:0]   pc_sum;
    logic                 pc_write;

    assign ra[0]    = bus.RA1;
    assign ra[1]    = bus.RA2;
    assign pc_sum   = {1'b0, regs[LAST]} + {1'b0, STEP};
    assign pc_write = bus.WE && (bus.WA == LAST);

    // PC reads carry the pipeline offset, taken from the pre-edge PC value
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_nxt[p] = (ra[p] == LAST) ? regs[LAST] + OFFSET : regs[ra[p]];
`ifdef REGISTER_BANK_BYPASS_EN
            if (bus.WE && (ra[p] == bus.WA)) begin
                rd_nxt[p] = (ra[p] == LAST) ? bus.WD + OFFSET : bus.WD;
            end
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                regs[i] <= '1;
            end
            regs[DEPTH-1] <= '0;
            rd_q[0]       <= '0;
            rd_q[1]       <= '0;
            wrap_q        <= 1'b0;
        end else begin
            wrap_q  <= 1'b0;
            rd_q[0] <= rd_nxt[0];
            rd_q[1] <= rd_nxt[1];
            if (bus.WE) begin
                regs[bus.WA] <= bus.WD;
            end
            // an explicit PC write overrides the auto-increment and never flags a wrap
            if (!pc_write && bus.PC_EN) begin
                regs[LAST] <= pc_sum[DATA_SIZE-1:0];
                wrap_q     <= pc_sum[DATA_SIZE];
            end
        end
    end

    assign bus.RD1     = rd_q[0];
    assign bus.RD2     = rd_q[1];
    assign bus.PC      = regs[LAST];
    assign bus.PC_WRAP = wrap_q;
endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed vector table, reset corner cases, random run vs model.
module tb_register_bank;
    localparam int DW = 32;
    localparam int AW = 4;
`ifdef REGISTER_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    register_bank_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

    register_bank #(.DATA_SIZE(DW), .DEPTH(16), .ADDR_SIZE(AW), .PC_STEP(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [3:0]    wa;
        logic [31:0]   wd;
        logic [3:0]    ra1;
        logic [3:0]    ra2;
        logic          pc_en;
        logic [31:0]   e_rd1;
        logic [31:0]   e_rd2;
        logic [31:0]   e_pc;
        logic          e_wrap;
    } vec_t;

    vec_t vecs [14];

    // behavioural reference: plain array of register contents plus the PC value
    logic [31:0] m_r [15];
    logic [31:0] m_pc;
    logic        m_wrap;
    logic [31:0] m_rd1, m_rd2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] ra1, input logic [3:0] ra2, input logic pc_en);
        bus.WE = we; bus.WA = wa; bus.WD = wd;
        bus.RA1 = ra1; bus.RA2 = ra2; bus.PC_EN = pc_en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] v;
        v = (a == 4'd15) ? m_pc + 32'd8 : m_r[a];
        if (BYP && bus.WE && a == bus.WA) v = (a == 4'd15) ? bus.WD + 32'd8 : bus.WD;
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 15; i++) m_r[i] = 32'hFFFF_FFFF;
        m_pc = 0; m_wrap = 0; m_rd1 = 0; m_rd2 = 0;
    endtask

    task automatic m_edge();
        logic [32:0] s;
        m_rd1  = m_read(bus.RA1);
        m_rd2  = m_read(bus.RA2);
        m_wrap = 1'b0;
        if (bus.WE && bus.WA == 4'd15) begin
            m_pc = bus.WD;
        end else begin
            if (bus.WE) m_r[bus.WA] = bus.WD;
            if (bus.PC_EN) begin
                s      = {1'b0, m_pc} + 33'd4;
                m_pc   = s[31:0];
                m_wrap = s[32];
            end
        end
    endtask

    initial begin
        vecs[0]  = '{0, 4'd0,  32'h0,        4'd3,  4'd15, 0, 32'hFFFF_FFFF, 32'h8,          32'h0,          0};
        vecs[1]  = '{1, 4'd5,  32'h1234_5678, 4'd0, 4'd0,  0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,          0};
        vecs[2]  = '{0, 4'd0,  32'h0,        4'd5,  4'd5,  0, 32'h1234_5678, 32'h1234_5678, 32'h0,          0};
        vecs[3]  = '{0, 4'd0,  32'h0,        4'd15, 4'd0,  1, 32'h8,         32'hFFFF_FFFF, 32'h4,          0};
        vecs[4]  = '{0, 4'd0,  32'h0,        4'd15, 4'd0,  1, 32'hC,         32'hFFFF_FFFF, 32'h8,          0};
        vecs[5]  = '{0, 4'd0,  32'h0,        4'd5,  4'd15, 1, 32'h1234_5678, 32'h10,        32'hC,          0};
        vecs[6]  = '{0, 4'd0,  32'h0,        4'd15, 4'd15, 0, 32'h14,        32'h14,        32'hC,          0};
        vecs[7]  = '{1, 4'd15, 32'hFFFF_FFFC, 4'd0, 4'd15, 0, 32'hFFFF_FFFF, BYP ? 32'h4 : 32'h14, 32'hFFFF_FFFC, 0};
        vecs[8]  = '{0, 4'd0,  32'h0,        4'd15, 4'd0,  1, 32'h4,         32'hFFFF_FFFF, 32'h0,          1};
        vecs[9]  = '{0, 4'd0,  32'h0,        4'd15, 4'd0,  0, 32'h8,         32'hFFFF_FFFF, 32'h0,          0};
        vecs[10] = '{1, 4'd15, 32'h100,      4'd15, 4'd0,  1, BYP ? 32'h108 : 32'h8, 32'hFFFF_FFFF, 32'h100, 0};
        vecs[11] = '{1, 4'd2,  32'hAAAA,     4'd2,  4'd0,  0, BYP ? 32'hAAAA : 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h100, 0};
        vecs[12] = '{1, 4'd2,  32'h5555,     4'd2,  4'd2,  0, BYP ? 32'h5555 : 32'hAAAA, BYP ? 32'h5555 : 32'hAAAA, 32'h100, 0};
        vecs[13] = '{0, 4'd0,  32'h0,        4'd2,  4'd15, 0, 32'h5555,      32'h108,       32'h100,        0};

        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(); tick();
        chk("rst_rd1", bus.RD1, 32'h0);
        chk("rst_rd2", bus.RD2, 32'h0);
        chk("rst_pc", bus.PC, 32'h0);
        chk("rst_wrap", {31'h0, bus.PC_WRAP}, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2, vecs[i].pc_en);
            tick();
            chk($sformatf("v%0d_rd1", i), bus.RD1, vecs[i].e_rd1);
            chk($sformatf("v%0d_rd2", i), bus.RD2, vecs[i].e_rd2);
            chk($sformatf("v%0d_pc", i), bus.PC, vecs[i].e_pc);
            chk($sformatf("v%0d_wrap", i), {31'h0, bus.PC_WRAP}, {31'h0, vecs[i].e_wrap});
        end

        // async reset while PC_WRAP is high and a write/increment is pending
        drive(1, 15, 32'hFFFF_FFFC, 0, 0, 0);
        tick();
        drive(0, 0, 0, 15, 3, 1);
        tick();
        chk("pre_async_wrap", {31'h0, bus.PC_WRAP}, 32'h1);
        drive(1, 3, 32'hDEAD_BEEF, 3, 15, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_wrap", {31'h0, bus.PC_WRAP}, 32'h0);
        chk("async_pc", bus.PC, 32'h0);
        chk("async_rd1", bus.RD1, 32'h0);
        tick();
        chk("hold_pc", bus.PC, 32'h0);
        rst = 1'b1;
        drive(0, 0, 0, 3, 15, 0);
        tick();
        chk("post_rst_r3", bus.RD1, 32'hFFFF_FFFF);
        chk("post_rst_r15", bus.RD2, 32'h8);

        // random run against the model
        rst = 1'b0;
        m_reset();
        tick();
        rst = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] wd;
            logic [3:0]  wa;
            wd = $urandom;
            wa = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) wd = 32'hFFFF_FFF0 | (wd & 32'hC);
            drive(1'($urandom_range(0, 2) == 0), wa, wd,
                  4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
            m_edge();
            tick();
            chk("rnd_rd1", bus.RD1, m_rd1);
            chk("rnd_rd2", bus.RD2, m_rd2);
            chk("rnd_pc", bus.PC, m_pc);
            chk("rnd_wrap", {31'h0, bus.PC_WRAP}, {31'h0, m_wrap});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
